// File: rtl/axi_read_slave_mem.sv
// AXI4 read-only slave backed by a word-addressed memory with a backdoor
// preload port. One burst outstanding at a time; FIXED/INCR/WRAP bursts,
// SLVERR for unsupported burst type, size or wrap length.
module axi_read_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ID_WIDTH-1:0]          s_ARID,
  input  logic [ADDR_WIDTH-1:0]        s_ARADDR,
  input  logic [7:0]                   s_ARLEN,
  input  logic [2:0]                   s_ARSIZE,
  input  logic [1:0]                   s_ARBURST,
  input  logic [USER_WIDTH-1:0]        s_ARUSER,
  input  logic                         s_ARVALID,
  output logic                         s_ARREADY,
  output logic [ID_WIDTH-1:0]          s_RID,
  output logic [DATA_WIDTH-1:0]        s_RDATA,
  output logic [1:0]                   s_RRESP,
  output logic                         s_RLAST,
  output logic [USER_WIDTH-1:0]        s_RUSER,
  output logic                         s_RVALID,
  input  logic                         s_RREADY,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0]        bd_wdata
);

  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam int         OFF_W     = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] FULL_SIZE = 3'(OFF_W);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLV  = 2'b10;

  typedef enum logic {IDLE, BURST} state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic                  err_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [USER_WIDTH-1:0] ruser_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic [7:0]            cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_d;

  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_err;
  logic [IDX_W-1:0]      wrap_mask;

  // Only the word-index bits of the address matter; the rest are ignored
  logic unused_addr;
  assign unused_addr = ^s_ARADDR;

  // Decode the incoming request: start word and whether it is answerable
  always_comb begin
    ar_idx = s_ARADDR[IDX_W+OFF_W-1:OFF_W];
    ar_err = (s_ARBURST == 2'b11) ||
             (s_ARSIZE != FULL_SIZE) ||
             ((s_ARBURST == 2'b10) &&
              !((s_ARLEN == 8'd1) || (s_ARLEN == 8'd3) ||
                (s_ARLEN == 8'd7) || (s_ARLEN == 8'd15)));
  end

  // Address of the following beat; a legal wrap length is 2^n-1 so it doubles as the window mask
  always_comb begin
    wrap_mask = IDX_W'(len_q);
    case (burst_q)
      2'b00:   idx_d = idx_q;
      2'b10:   idx_d = (idx_q & ~wrap_mask) | ((idx_q + IDX_W'(1)) & wrap_mask);
      default: idx_d = idx_q + IDX_W'(1);
    endcase
  end

  // Backdoor preload port; memory contents survive reset
  always_ff @(posedge ACLK) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
  end

  // Request/burst FSM with registered handshake and beat payload
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      err_q     <= 1'b0;
      rid_q     <= '0;
      ruser_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      len_q     <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && s_ARVALID) begin
            state_q   <= BURST;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= s_ARID;
            ruser_q   <= s_ARUSER;
            len_q     <= s_ARLEN;
            burst_q   <= s_ARBURST;
            err_q     <= ar_err;
            idx_q     <= ar_idx;
            cnt_q     <= '0;
            rlast_q   <= (s_ARLEN == 8'd0);
            rresp_q   <= ar_err ? RESP_SLV : RESP_OKAY;
            rdata_q   <= ar_err ? '0 : mem[ar_idx];
          end
        end
        BURST: begin
          if (s_RREADY) begin
            if (rlast_q) begin
              state_q   <= IDLE;
              rvalid_q  <= 1'b0;
              arready_q <= 1'b1;
              rlast_q   <= 1'b0;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              rlast_q <= ((cnt_q + 8'd1) == len_q);
              idx_q   <= idx_d;
              rdata_q <= err_q ? '0 : mem[idx_d];
            end
          end
        end
      endcase
    end
  end

  assign s_ARREADY = arready_q;
  assign s_RVALID  = rvalid_q;
  assign s_RLAST   = rlast_q;
  assign s_RID     = rid_q;
  assign s_RUSER   = ruser_q;
  assign s_RDATA   = rdata_q;
  assign s_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// Directed bench for axi_read_slave_mem: preload, burst types, stalls,
// error responses, mid-burst reset and backdoor/read collision.
module tb_axi_read_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  s_ARID;
  logic [63:0] s_ARADDR;
  logic [7:0]  s_ARLEN;
  logic [2:0]  s_ARSIZE;
  logic [1:0]  s_ARBURST;
  logic [7:0]  s_ARUSER;
  logic        s_ARVALID;
  logic        s_ARREADY;
  logic [7:0]  s_RID;
  logic [31:0] s_RDATA;
  logic [1:0]  s_RRESP;
  logic        s_RLAST;
  logic [7:0]  s_RUSER;
  logic        s_RVALID;
  logic        s_RREADY;
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_wdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_data [16];

  always #5 ACLK = ~ACLK;

  axi_read_slave_mem #(
    .DATA_WIDTH(32), .ADDR_WIDTH(64), .ID_WIDTH(8), .USER_WIDTH(8), .MEM_DEPTH(256)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
    .s_ARBURST(s_ARBURST), .s_ARUSER(s_ARUSER), .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
    .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
    .s_RUSER(s_RUSER), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one AR request from a negedge; returns at the negedge of the first beat
  task automatic send_ar(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [7:0] id, input logic [7:0] user,
                         input bit hold);
    check("arready_before_ar", 64'(s_ARREADY), 64'd1);
    s_ARADDR  = addr;
    s_ARLEN   = len;
    s_ARBURST = burst;
    s_ARSIZE  = size;
    s_ARID    = id;
    s_ARUSER  = user;
    s_ARVALID = 1'b1;
    @(negedge ACLK);
    if (!hold) s_ARVALID = 1'b0;
  endtask

  // Collect n beats; pat bit c is RREADY in cycle c (1 beyond bit 15)
  task automatic read_beats(input int n, input logic [1:0] resp, input logic [7:0] id,
                            input logic [7:0] user, input logic [15:0] pat);
    int beat = 0;
    int cyc = 0;
    while (beat < n && cyc < 64) begin
      check("rvalid", 64'(s_RVALID), 64'd1);
      check("arready_busy", 64'(s_ARREADY), 64'd0);
      check("rdata", 64'(s_RDATA), 64'(exp_data[beat]));
      check("rresp", 64'(s_RRESP), 64'(resp));
      check("rid", 64'(s_RID), 64'(id));
      check("ruser", 64'(s_RUSER), 64'(user));
      check("rlast", 64'(s_RLAST), 64'(beat == n - 1));
      s_RREADY = (cyc < 16) ? pat[cyc] : 1'b1;
      @(negedge ACLK);
      if (s_RREADY) beat++;
      cyc++;
    end
    check("beats_done", 64'(beat), 64'(n));
    s_RREADY  = 1'b0;
    s_ARVALID = 1'b0;
    check("rvalid_after", 64'(s_RVALID), 64'd0);
    check("arready_after", 64'(s_ARREADY), 64'd1);
    $display("read id=0x%0h beats=%0d resp=%0d cycles=%0d", id, n, resp, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    s_ARID = '0; s_ARADDR = '0; s_ARLEN = '0; s_ARSIZE = 3'd2; s_ARBURST = 2'b01;
    s_ARUSER = '0; s_ARVALID = 1'b0; s_RREADY = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    repeat (2) @(negedge ACLK);
    check("rst_arready", 64'(s_ARREADY), 64'd0);
    check("rst_rvalid", 64'(s_RVALID), 64'd0);
    check("rst_rlast", 64'(s_RLAST), 64'd0);
    check("rst_rdata", 64'(s_RDATA), 64'd0);
    check("rst_rid", 64'(s_RID), 64'd0);
    check("rst_rresp", 64'(s_RRESP), 64'd0);
    check("rst_ruser", 64'(s_RUSER), 64'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("arready_after_rst", 64'(s_ARREADY), 64'd1);

    // preload mem[0..7] = 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      bd_we = 1'b1; bd_addr = 8'(i); bd_wdata = 32'h10 + 32'(i);
      @(negedge ACLK);
    end
    bd_we = 1'b0;
    $display("preload mem[0..7] done");

    // INCR from word 2
    exp_data[0] = 32'h12; exp_data[1] = 32'h13; exp_data[2] = 32'h14; exp_data[3] = 32'h15;
    send_ar(64'h8, 8'd3, 2'b01, 3'd2, 8'h21, 8'h5A, 1'b0);
    read_beats(4, 2'b00, 8'h21, 8'h5A, 16'hFFFF);

    // WRAP from word 6 in window 4..7
    exp_data[0] = 32'h16; exp_data[1] = 32'h17; exp_data[2] = 32'h14; exp_data[3] = 32'h15;
    send_ar(64'h18, 8'd3, 2'b10, 3'd2, 8'h33, 8'hC3, 1'b0);
    read_beats(4, 2'b00, 8'h33, 8'hC3, 16'hFFFF);

    // FIXED with stalls, ARVALID held throughout
    exp_data[0] = 32'h11; exp_data[1] = 32'h11; exp_data[2] = 32'h11;
    send_ar(64'h4, 8'd2, 2'b00, 3'd2, 8'h44, 8'h01, 1'b1);
    read_beats(3, 2'b00, 8'h44, 8'h01, 16'hFFF9);
    @(negedge ACLK);
    check("no_extra_accept", 64'(s_RVALID), 64'd0);

    // reserved burst type
    exp_data[0] = 32'h0; exp_data[1] = 32'h0;
    send_ar(64'h0, 8'd1, 2'b11, 3'd2, 8'h55, 8'h77, 1'b0);
    read_beats(2, 2'b10, 8'h55, 8'h77, 16'hFFFF);

    // WRAP with illegal length
    exp_data[0] = 32'h0; exp_data[1] = 32'h0; exp_data[2] = 32'h0;
    send_ar(64'h4, 8'd2, 2'b10, 3'd2, 8'h66, 8'h88, 1'b0);
    read_beats(3, 2'b10, 8'h66, 8'h88, 16'hFFFF);

    // narrow size
    exp_data[0] = 32'h0;
    send_ar(64'h4, 8'd0, 2'b01, 3'd1, 8'h67, 8'h89, 1'b0);
    read_beats(1, 2'b10, 8'h67, 8'h89, 16'hFFFF);

    // reset during beat 2 of an 8-beat burst
    send_ar(64'h0, 8'd7, 2'b01, 3'd2, 8'h77, 8'h99, 1'b0);
    s_RREADY = 1'b1;
    repeat (2) @(negedge ACLK);
    check("midburst_rdata", 64'(s_RDATA), 64'h12);
    ARESET = 1'b1;
    s_RREADY = 1'b0;
    #1;
    check("async_rvalid", 64'(s_RVALID), 64'd0);
    check("async_arready", 64'(s_ARREADY), 64'd0);
    check("async_rlast", 64'(s_RLAST), 64'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("post_rst_arready", 64'(s_ARREADY), 64'd1);
    check("post_rst_rvalid", 64'(s_RVALID), 64'd0);
    $display("reset mid-burst applied");
    exp_data[0] = 32'h17;
    send_ar(64'h1C, 8'd0, 2'b01, 3'd2, 8'h88, 8'hAB, 1'b0);
    read_beats(1, 2'b00, 8'h88, 8'hAB, 16'hFFFF);

    // backdoor write to the word being loaded at the AR edge
    bd_we = 1'b1; bd_addr = 8'd3; bd_wdata = 32'hAA;
    exp_data[0] = 32'h13; exp_data[1] = 32'hAA;
    send_ar(64'hC, 8'd1, 2'b00, 3'd2, 8'h99, 8'hCD, 1'b0);
    bd_we = 1'b0;
    read_beats(2, 2'b00, 8'h99, 8'hCD, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
